// File: rtl/fcpu_pkg.sv
// fcpu_pkg: shared CPU-wide widths and opcode constants.
//   DATA_W   - datapath / address width
//   RSV_ID_W - reservation-station (ROB) id width
//   INSTR_W  - opcode width
//   CDB_W    - common-data-bus word, {rsv_id, data}
// Helper functions classify memory opcodes so the decode lives in one place.
package fcpu_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned RSV_ID_W = 4;
    localparam int unsigned INSTR_W  = 6;
    localparam int unsigned CDB_W    = RSV_ID_W + DATA_W;

    typedef logic [INSTR_W-1:0] opcode_t;

    localparam opcode_t OP_NOP    = 6'd0;
    localparam opcode_t OP_ADD    = 6'd1;
    localparam opcode_t OP_SUB    = 6'd2;
    localparam opcode_t OP_LOAD   = 6'd8;
    localparam opcode_t OP_LOADR  = 6'd9;
    localparam opcode_t OP_LOADB  = 6'd10;
    localparam opcode_t OP_STORE  = 6'd11;
    localparam opcode_t OP_STORER = 6'd12;
    localparam opcode_t OP_STOREB = 6'd13;
    localparam opcode_t OP_INPUT  = 6'd14;
    localparam opcode_t OP_OUTPUT = 6'd15;

    function automatic logic op_is_load(input opcode_t op);
        return (op == OP_LOAD) || (op == OP_LOADR) || (op == OP_LOADB);
    endfunction

    function automatic logic op_is_store(input opcode_t op);
        return (op == OP_STORE) || (op == OP_STORER) || (op == OP_STOREB);
    endfunction

endpackage

// File: rtl/data_ram.sv
// data_ram: single-port word RAM with per-byte write enables.
//   clk_i   - clock
//   we_i    - write enable, lanes selected by be_i (lane 0 = bits [7:0])
//   be_i    - 4-bit byte enable
//   re_i    - read enable; rdata_o updates one cycle later and holds otherwise
//   addr_i  - word index
//   wdata_i - write data
//   rdata_o - registered read data
// No reset: contents survive a system reset.
module data_ram
    import fcpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [3:0]        be_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [Depth];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mmu_responder.sv
// mmu_responder: memory/IO unit behind the reservation stations.
// Accepts one request at a time (mmu_valid/mmu_ready), serves loads and stores
// from an internal data_ram, byte I/O through the io_in/io_out ports, and
// returns load/input results on the CDB as {rsv_id, data}.
//   clk, nrst                 - clock, async active-low reset
//   mmu_rsv_id/valid/data/
//   addr/opcode, mmu_ready    - request channel
//   mmu_cdb, mmu_cdb_valid,
//   mmu_cdb_ready             - result channel
//   io_in_*                   - input byte port (consumed in IN)
//   io_out_*                  - output byte port (driven in OUT)
// Stores and OUTPUT produce no CDB result; unknown opcodes are dropped.
module mmu_responder
    import fcpu_pkg::*;
#(
    parameter int unsigned DMEM_ADDR_W = 12
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic [RSV_ID_W-1:0] mmu_rsv_id,
    input  logic                mmu_valid,
    input  logic [DATA_W-1:0]   mmu_data,
    input  logic [DATA_W-1:0]   mmu_addr,
    input  logic [INSTR_W-1:0]  mmu_opcode,
    output logic                mmu_ready,
    output logic [CDB_W-1:0]    mmu_cdb,
    output logic                mmu_cdb_valid,
    input  logic                mmu_cdb_ready,
    input  logic [7:0]          io_in_data,
    input  logic                io_in_valid,
    output logic                io_in_ready,
    output logic [7:0]          io_out_data,
    output logic                io_out_valid,
    input  logic                io_out_ready
);

    typedef enum logic [2:0] {StIdle, StRd, StWr, StIn, StOut, StResp} state_e;

    state_e                state_q, state_d;
    logic [RSV_ID_W-1:0]   id_q, id_d;
    logic [INSTR_W-1:0]    op_q, op_d;
    logic [DATA_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     data_q, data_d;

    logic                  ram_we;
    logic                  ram_re;
    logic [3:0]            ram_be;
    logic [DMEM_ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0]     ram_wdata;
    logic [DATA_W-1:0]     ram_rdata;
    logic [4:0]            lane_bit;
    logic [DATA_W-1:0]     result;

    // Address bits above the RAM index are ignored so accesses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_q[DATA_W-1:DMEM_ADDR_W+2];

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        op_d    = op_q;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                if (mmu_valid) begin
                    id_d   = mmu_rsv_id;
                    op_d   = mmu_opcode;
                    addr_d = mmu_addr;
                    data_d = mmu_data;
                    if (op_is_load(mmu_opcode)) begin
                        state_d = StRd;
                    end else if (op_is_store(mmu_opcode)) begin
                        state_d = StWr;
                    end else if (mmu_opcode == OP_INPUT) begin
                        state_d = StIn;
                    end else if (mmu_opcode == OP_OUTPUT) begin
                        state_d = StOut;
                    end
                end
            end
            StRd: state_d = StResp;
            StWr: state_d = StIdle;
            StIn: begin
                if (io_in_valid) begin
                    // The input byte reuses the data field as the response value.
                    data_d  = {{(DATA_W-8){1'b0}}, io_in_data};
                    state_d = StResp;
                end
            end
            StOut: begin
                if (io_out_ready) begin
                    state_d = StIdle;
                end
            end
            StResp: begin
                if (mmu_cdb_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= StIdle;
            id_q    <= '0;
            op_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // ---------------------------------------------------------------- data RAM
    always_comb begin
        ram_we    = (state_q == StWr);
        ram_re    = (state_q == StRd);
        ram_addr  = addr_q[DMEM_ADDR_W+1:2];
        ram_be    = 4'hF;
        ram_wdata = data_q;
        if (op_q == OP_STOREB) begin
            ram_be    = 4'b0001 << addr_q[1:0];
            ram_wdata = {4{data_q[7:0]}};
        end
    end

    data_ram #(
        .ADDR_W (DMEM_ADDR_W)
    ) u_data_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .be_i    (ram_be),
        .re_i    (ram_re),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // ---------------------------------------------------------------- outputs
    // RAM read data holds while in RESP because no new read is issued there.
    always_comb begin
        lane_bit = {addr_q[1:0], 3'b000};
        result   = data_q;
        if (op_is_load(op_q)) begin
            result = ram_rdata;
            if (op_q == OP_LOADB) begin
                result = {{(DATA_W-8){1'b0}}, ram_rdata[lane_bit +: 8]};
            end
        end
    end

    always_comb begin
        mmu_ready     = (state_q == StIdle);
        mmu_cdb_valid = (state_q == StResp);
        mmu_cdb       = (state_q == StResp) ? {id_q, result} : '0;
        io_in_ready   = (state_q == StIn);
        io_out_valid  = (state_q == StOut);
        io_out_data   = (state_q == StOut) ? data_q[7:0] : 8'h00;
    end

endmodule
